bcd_scan_counter: RTL

BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

---
 rtl/bcd_scan_counter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with programmable prescaler and a
// multiplexed seven-segment scan driver with optional leading-zero blanking.
module bcd_scan_counter #(
  parameter int          NUM_DIGITS = 4,
  parameter logic [23:0] MAX_COUNT  = 24'd10_000_000,
  parameter logic [15:0] SCAN_DIV   = 16'd10_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    up_down,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic [7:0]              rate_sel,
  input  logic                    blank_lz,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic [6:0]              segments,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    wrap
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [23:0]             prescaler;
  logic [23:0]             compare;
  logic                    tick;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [4*NUM_DIGITS-1:0] step_digits;
  logic [4*NUM_DIGITS-1:0] load_sat;
  logic                    carry;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    lz_seen;
  logic [15:0]             scan_cnt;
  logic [IW-1:0]           scan_idx;
  logic [3:0]              cur_digit;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   sel_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  assign compare   = (rate_sel == 8'd0) ? MAX_COUNT : {6'b0, rate_sel, 10'b0};
  assign tick      = enable && (prescaler >= compare);
  assign count_bcd = digits;

  // >= rather than == so a compare lowered mid-count fires immediately instead of overrunning
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= 24'd0;
    end else if (clear || load) begin
      prescaler <= 24'd0;
    end else if (enable) begin
      if (prescaler >= compare) prescaler <= 24'd0;
      else                      prescaler <= prescaler + 24'd1;
    end
  end

  // Ripple carry/borrow through all digits; a carry out of the top digit means wrap-around
  always_comb begin
    step_digits = digits;
    carry       = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (up_down) begin
          if (digits[4*i +: 4] >= 4'd9) begin
            step_digits[4*i +: 4] = 4'd0;
          end else begin
            step_digits[4*i +: 4] = digits[4*i +: 4] + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (digits[4*i +: 4] == 4'd0) begin
            step_digits[4*i +: 4] = 4'd9;
          end else begin
            step_digits[4*i +: 4] = digits[4*i +: 4] - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    load_sat = load_value;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (load_value[4*i +: 4] > 4'd9) load_sat[4*i +: 4] = 4'd9;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits <= '0;
      wrap   <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clear) begin
        digits <= '0;
      end else if (load) begin
        digits <= load_sat;
      end else if (tick) begin
        digits <= step_digits;
        wrap   <= carry;
      end
    end
  end

  // Blank a digit when it and every digit above it are zero; digit 0 always shows
  always_comb begin
    blank_mask = '0;
    lz_seen    = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (digits[4*i +: 4] != 4'd0) lz_seen = 1'b1;
      blank_mask[i] = blank_lz && !lz_seen;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= 16'd0;
      scan_idx <= '0;
    end else if (scan_cnt >= SCAN_DIV - 16'd1) begin
      scan_cnt <= 16'd0;
      if (scan_idx == IW'(NUM_DIGITS - 1)) scan_idx <= '0;
      else                                 scan_idx <= scan_idx + IW'(1);
    end else begin
      scan_cnt <= scan_cnt + 16'd1;
    end
  end

  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    sel_next  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx == IW'(i)) begin
        cur_digit   = digits[4*i +: 4];
        cur_blank   = blank_mask[i];
        sel_next[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_sel <= NUM_DIGITS'(1);
      segments  <= 7'h3F;
    end else begin
      digit_sel <= sel_next;
      segments  <= cur_blank ? 7'h00 : seg_decode(cur_digit);
    end
  end

endmodule
